// File: rtl/memory_access_unit_pkg.sv
// mau_pkg: size encodings, FSM states and strobe helper for the memory access unit
package mau_pkg;
  localparam logic [1:0] MAU_SZ_B = 2'b00;
  localparam logic [1:0] MAU_SZ_H = 2'b01;
  localparam logic [1:0] MAU_SZ_W = 2'b10;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} mau_state_e;
  function automatic logic [3:0] mau_strb(input logic [1:0] sz);
    return sz == MAU_SZ_B ? 4'b0001 : sz == MAU_SZ_H ? 4'b0011 : 4'b1111;
  endfunction
endpackage

// File: rtl/memory_access_unit_if.sv
// memory_access_unit_if: request/response handshake and memory port of the load/store unit
interface memory_access_unit_if;
  logic        iwReqValid, owReqReady, iwReqWrite, iwReqUnsigned;
  logic [1:0]  iwReqSize;
  logic [31:0] iwReqAddr, iwReqWData;
  logic        orRspValid, iwRspReady, orRspFault;
  logic [31:0] orRspData;
  logic [31:0] orMemReadAddr, orMemWriteAddr, orMemWriteData, iwMemReadData;
  logic [3:0]  orMemWstrb;
  modport master (
    output iwReqValid, iwReqWrite, iwReqSize, iwReqUnsigned, iwReqAddr, iwReqWData, iwRspReady, iwMemReadData,
    input  owReqReady, orRspValid, orRspData, orRspFault, orMemReadAddr, orMemWriteAddr, orMemWriteData, orMemWstrb
  );
  modport slave (
    input  iwReqValid, iwReqWrite, iwReqSize, iwReqUnsigned, iwReqAddr, iwReqWData, iwRspReady, iwMemReadData,
    output owReqReady, orRspValid, orRspData, orRspFault, orMemReadAddr, orMemWriteAddr, orMemWriteData, orMemWstrb
  );
endinterface

// File: rtl/memory_access_unit_load_format.sv
// mau_load_format: zero/sign extension of byte, half and word load data
module mau_load_format
  import mau_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);
  assign result = size == MAU_SZ_B ? {{24{~uns & data[7]}}, data[7:0]} :
                  size == MAU_SZ_H ? {{16{~uns & data[15]}}, data[15:0]} : data;
endmodule

// File: rtl/memory_access_unit.sv
// memory_access_unit: one-at-a-time load/store initiator with range/alignment fault detection
module memory_access_unit
  import mau_pkg::*;
#(
  parameter logic [31:0] pWords      = 32'd128,
  parameter bit          pCheckAlign = 1'b0
) (
  input logic iwClk,
  input logic iwRst,
  memory_access_unit_if.slave bus
);
  mau_state_e  state, next;
  logic        op_write, op_unsigned, rsp_fault, accept, fault, misalign, range_bad;
  logic [1:0]  op_size;
  logic [31:0] rsp_data, mem_raddr, mem_waddr, mem_wdata, fmt;
  logic [3:0]  mem_wstrb;
  logic [33:0] nbytes;
  mau_load_format u_fmt (.data(bus.iwMemReadData), .size(op_size), .uns(op_unsigned), .result(fmt));
  assign accept = bus.iwReqValid && state == IDLE;
  assign nbytes = bus.iwReqSize == MAU_SZ_B ? 34'd1 : bus.iwReqSize == MAU_SZ_H ? 34'd2 : 34'd4;
  // widened so addresses near 2^32 cannot wrap into the legal window
  assign range_bad = ({2'b00, bus.iwReqAddr} + nbytes) > {pWords, 2'b00};
  assign misalign = bus.iwReqSize == MAU_SZ_H ? bus.iwReqAddr[0] :
                    bus.iwReqSize == MAU_SZ_W ? |bus.iwReqAddr[1:0] : 1'b0;
  assign fault = bus.iwReqSize == 2'b11 || range_bad || (pCheckAlign && misalign);
  always_comb begin
    next = state;
    next = state == IDLE  ? (accept ? (fault ? RESP : ISSUE) : IDLE) :
           state == ISSUE ? (op_write ? RESP : WAIT) :
           state == WAIT  ? RESP :
           (bus.iwRspReady ? IDLE : RESP);
  end
  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      state       <= IDLE;
      op_write    <= 1'b0;
      op_size     <= MAU_SZ_B;
      op_unsigned <= 1'b0;
      rsp_data    <= '0;
      rsp_fault   <= 1'b0;
      mem_raddr   <= '0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
    end else begin
      state <= next;
      if (accept) begin
        op_write    <= bus.iwReqWrite;
        op_size     <= bus.iwReqSize;
        op_unsigned <= bus.iwReqUnsigned;
        rsp_data    <= '0;
        rsp_fault   <= fault;
        if (!fault && !bus.iwReqWrite) mem_raddr <= bus.iwReqAddr;
        if (!fault && bus.iwReqWrite) begin
          mem_waddr <= bus.iwReqAddr;
          mem_wdata <= bus.iwReqWData;
          mem_wstrb <= mau_strb(bus.iwReqSize);
        end
      end
      if (state == ISSUE) begin
        mem_wstrb <= '0;
        rsp_data  <= '0;
        rsp_fault <= 1'b0;
      end
      if (state == WAIT) begin
        rsp_data  <= fmt;
        rsp_fault <= 1'b0;
      end
    end
  end
  assign bus.owReqReady     = state == IDLE;
  assign bus.orRspValid     = state == RESP;
  assign bus.orRspData      = rsp_data;
  assign bus.orRspFault     = rsp_fault;
  assign bus.orMemReadAddr  = mem_raddr;
  assign bus.orMemWriteAddr = mem_waddr;
  assign bus.orMemWriteData = mem_wdata;
  assign bus.orMemWstrb     = mem_wstrb;
endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: directed vectors against a byte-addressed memory model, plus an alignment-checking twin
module tb_memory_access_unit;
  logic iwClk = 1'b0, iwRst = 1'b1;
  int checks = 0, errors = 0, wr_count = 0, a_cnt = 0;
  logic a_fault = 1'b0;
  logic [7:0] mem [0:511];
  memory_access_unit_if b0 ();
  memory_access_unit_if b1 ();
  memory_access_unit #(.pWords(32'd128), .pCheckAlign(1'b0)) dut (.iwClk(iwClk), .iwRst(iwRst), .bus(b0));
  memory_access_unit #(.pWords(32'd128), .pCheckAlign(1'b1)) dut_a (.iwClk(iwClk), .iwRst(iwRst), .bus(b1));
  always #5 iwClk = ~iwClk;
  assign b1.iwReqValid    = b0.iwReqValid;
  assign b1.iwReqWrite    = b0.iwReqWrite;
  assign b1.iwReqSize     = b0.iwReqSize;
  assign b1.iwReqUnsigned = b0.iwReqUnsigned;
  assign b1.iwReqAddr     = b0.iwReqAddr;
  assign b1.iwReqWData    = b0.iwReqWData;
  assign b1.iwRspReady    = 1'b1;
  assign b1.iwMemReadData = '0;
  function automatic logic [7:0] rd(input logic [31:0] a, input int k);
    logic [32:0] s;
    s = {1'b0, a} + 33'(k);
    return s < 33'd512 ? mem[s[8:0]] : 8'h00;
  endfunction
  always @(posedge iwClk) begin
    b0.iwMemReadData <= {rd(b0.orMemReadAddr, 3), rd(b0.orMemReadAddr, 2), rd(b0.orMemReadAddr, 1), rd(b0.orMemReadAddr, 0)};
    for (int k = 0; k < 4; k++)
      if (b0.orMemWstrb[k] && ({1'b0, b0.orMemWriteAddr} + 33'(k)) < 33'd512)
        mem[9'(b0.orMemWriteAddr + 32'(k))] <= b0.orMemWriteData[8*k +: 8];
    if (|b0.orMemWstrb) wr_count++;
  end
  always @(negedge iwClk)
    if (b1.orRspValid) begin
      a_fault = b1.orRspFault;
      a_cnt++;
    end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", name, act, exp);
    end
  endtask
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] data, output logic fault, output int lat);
    b0.iwReqValid = 1'b1; b0.iwReqWrite = wr; b0.iwReqSize = sz; b0.iwReqUnsigned = uns;
    b0.iwReqAddr = addr; b0.iwReqWData = wdata;
    lat = 0;
    while (lat < 10) begin
      @(posedge iwClk); lat++; #1;
      if (lat == 1) b0.iwReqValid = 1'b0;
      if (b0.orRspValid) break;
    end
    data = b0.orRspData; fault = b0.orRspFault;
    @(posedge iwClk); #1;
  endtask
  typedef struct {
    string name; logic wr; logic [1:0] sz; logic uns; logic [31:0] addr, wdata, exp_data;
    logic exp_fault, exp_afault; int exp_lat;
  } vec_t;
  vec_t v [20];
  logic [31:0] data, exp_raddr, held;
  logic fault;
  int lat, wr0, a0;
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    b0.iwReqValid = 0; b0.iwReqWrite = 0; b0.iwReqSize = 0; b0.iwReqUnsigned = 0;
    b0.iwReqAddr = 0; b0.iwReqWData = 0; b0.iwRspReady = 1;
    v[0]  = '{"st_w_10",   1, 2'b10, 0, 32'h10,       32'h11223344, 32'h0,        0, 0, 2};
    v[1]  = '{"ld_w_10",   0, 2'b10, 0, 32'h10,       32'h0,        32'h11223344, 0, 0, 3};
    v[2]  = '{"st_b_21",   1, 2'b00, 0, 32'h21,       32'hAB,       32'h0,        0, 0, 2};
    v[3]  = '{"ld_bs_21",  0, 2'b00, 0, 32'h21,       32'h0,        32'hFFFFFFAB, 0, 0, 3};
    v[4]  = '{"ld_bu_21",  0, 2'b00, 1, 32'h21,       32'h0,        32'h000000AB, 0, 0, 3};
    v[5]  = '{"ld_bu_20",  0, 2'b00, 1, 32'h20,       32'h0,        32'h00000020, 0, 0, 3};
    v[6]  = '{"ld_bu_22",  0, 2'b00, 1, 32'h22,       32'h0,        32'h00000022, 0, 0, 3};
    v[7]  = '{"st_h_40",   1, 2'b01, 0, 32'h40,       32'h8001,     32'h0,        0, 0, 2};
    v[8]  = '{"ld_hs_40",  0, 2'b01, 0, 32'h40,       32'h0,        32'hFFFF8001, 0, 0, 3};
    v[9]  = '{"ld_hu_40",  0, 2'b01, 1, 32'h40,       32'h0,        32'h00008001, 0, 0, 3};
    v[10] = '{"ld_w_1fd",  0, 2'b10, 0, 32'h1FD,      32'h0,        32'h0,        1, 1, 1};
    v[11] = '{"ld_w_1fc",  0, 2'b10, 0, 32'h1FC,      32'h0,        32'hFFFEFDFC, 0, 0, 3};
    v[12] = '{"ld_sz11",   0, 2'b11, 0, 32'h0,        32'h0,        32'h0,        1, 1, 1};
    v[13] = '{"ld_b_ffff", 0, 2'b00, 1, 32'hFFFFFFFF, 32'h0,        32'h0,        1, 1, 1};
    v[14] = '{"st_w_wrap", 1, 2'b10, 0, 32'hFFFFFFFC, 32'h99,       32'h0,        1, 1, 1};
    v[15] = '{"ld_hu_41",  0, 2'b01, 1, 32'h41,       32'h0,        32'h00004280, 0, 1, 3};
    v[16] = '{"ld_w_42",   0, 2'b10, 0, 32'h42,       32'h0,        32'h45444342, 0, 1, 3};
    v[17] = '{"st_b_1ff",  1, 2'b00, 0, 32'h1FF,      32'h77,       32'h0,        0, 0, 2};
    v[18] = '{"ld_bs_1ff", 0, 2'b00, 0, 32'h1FF,      32'h0,        32'h00000077, 0, 0, 3};
    v[19] = '{"ld_h_1ff",  0, 2'b01, 0, 32'h1FF,      32'h0,        32'h0,        1, 1, 1};
    #1;
    check("rst_ready", 32'(b0.owReqReady), 1);
    check("rst_valid", 32'(b0.orRspValid), 0);
    check("rst_data", b0.orRspData, 0);
    check("rst_fault", 32'(b0.orRspFault), 0);
    check("rst_raddr", b0.orMemReadAddr, 0);
    check("rst_waddr", b0.orMemWriteAddr, 0);
    check("rst_wdata", b0.orMemWriteData, 0);
    check("rst_wstrb", 32'(b0.orMemWstrb), 0);
    #12 iwRst = 0;
    @(posedge iwClk); #1;
    exp_raddr = 0;
    for (int i = 0; i < 20; i++) begin
      wr0 = wr_count; a0 = a_cnt;
      do_req(v[i].wr, v[i].sz, v[i].uns, v[i].addr, v[i].wdata, data, fault, lat);
      if (!v[i].wr && !v[i].exp_fault) exp_raddr = v[i].addr;
      check({v[i].name, "_data"}, data, v[i].exp_data);
      check({v[i].name, "_fault"}, 32'(fault), 32'(v[i].exp_fault));
      check({v[i].name, "_lat"}, 32'(lat), 32'(v[i].exp_lat));
      check({v[i].name, "_writes"}, 32'(wr_count - wr0), 32'(v[i].wr && !v[i].exp_fault));
      check({v[i].name, "_raddr"}, b0.orMemReadAddr, exp_raddr);
      check({v[i].name, "_ready"}, 32'(b0.owReqReady), 1);
      check({v[i].name, "_a_seen"}, 32'(a_cnt - a0), 1);
      check({v[i].name, "_a_fault"}, 32'(a_fault), 32'(v[i].exp_afault));
    end
    // response held while the consumer stalls
    b0.iwRspReady = 0;
    do_req(0, 2'b10, 0, 32'h10, 0, data, fault, lat);
    check("hold_lat", 32'(lat), 3);
    for (int c = 0; c < 5; c++) begin
      check("hold_valid", 32'(b0.orRspValid), 1);
      check("hold_data", b0.orRspData, 32'h11223344);
      check("hold_ready", 32'(b0.owReqReady), 0);
      @(posedge iwClk); #1;
    end
    b0.iwRspReady = 1;
    @(posedge iwClk); #1;
    check("hold_release_valid", 32'(b0.orRspValid), 0);
    check("hold_release_ready", 32'(b0.owReqReady), 1);
    // reset asserted while a store is in ISSUE aborts the write
    wr0 = wr_count;
    b0.iwReqValid = 1; b0.iwReqWrite = 1; b0.iwReqSize = 2'b10; b0.iwReqAddr = 32'h80; b0.iwReqWData = 32'hDEADBEEF;
    @(posedge iwClk); #1;
    b0.iwReqValid = 0;
    check("abort_issue_wstrb", 32'(b0.orMemWstrb), 32'hF);
    #1 iwRst = 1;
    #1;
    check("abort_wstrb_async", 32'(b0.orMemWstrb), 0);
    check("abort_ready", 32'(b0.owReqReady), 1);
    #3 iwRst = 0;
    @(posedge iwClk); #1;
    check("abort_no_write", 32'(wr_count - wr0), 0);
    check("abort_idle_valid", 32'(b0.orRspValid), 0);
    do_req(0, 2'b10, 0, 32'h80, 0, data, fault, lat);
    check("abort_mem_data", data, 32'h83828180);
    check("abort_mem_fault", 32'(fault), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
